// File: rtl/alarm_beeper.sv
// Alarm beeper: turns an alarm request into a gated square-wave burst pattern
// with snooze, stop, auto-timeout and an arm switch that cancels everything.
module alarm_beeper #(
    parameter int TONE_HALF     = 4,
    parameter int BEEP_ON_LEN   = 16,
    parameter int BEEP_OFF_LEN  = 16,
    parameter int SNOOZE_LEN    = 64,
    parameter int TIMEOUT_BEEPS = 8,
    parameter int MAX_SNOOZE    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       alarm_in,
    input  logic       arm,
    input  logic       snooze,
    input  logic       stop,
    output logic       tone_out,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_cnt,
    output logic [2:0] state_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_BEEP_ON  = 3'd1;
    localparam logic [2:0] S_BEEP_OFF = 3'd2;
    localparam logic [2:0] S_SNOOZE   = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    // The phase counter is shared by all timed states, so it is sized for the longest one.
    localparam int PHASE_MAX = (BEEP_ON_LEN > BEEP_OFF_LEN)
                             ? ((BEEP_ON_LEN > SNOOZE_LEN) ? BEEP_ON_LEN : SNOOZE_LEN)
                             : ((BEEP_OFF_LEN > SNOOZE_LEN) ? BEEP_OFF_LEN : SNOOZE_LEN);
    localparam int PW = $clog2(PHASE_MAX + 1);
    localparam int TW = $clog2(TONE_HALF + 1);
    localparam int BW = $clog2(TIMEOUT_BEEPS + 1);

    localparam logic [PW-1:0] ON_LAST   = PW'(BEEP_ON_LEN - 1);
    localparam logic [PW-1:0] OFF_LAST  = PW'(BEEP_OFF_LEN - 1);
    localparam logic [PW-1:0] SNZ_LAST  = PW'(SNOOZE_LEN - 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(TIMEOUT_BEEPS - 1);
    localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

    logic [2:0]    state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [TW-1:0] tone_cnt, tone_cnt_n;
    logic [BW-1:0] beep_cnt, beep_cnt_n;
    logic [1:0]    snz_n;
    logic          tone_n;
    logic          is_ringing;

    assign is_ringing = (state == S_BEEP_ON) || (state == S_BEEP_OFF);

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        tone_cnt_n = tone_cnt;
        beep_cnt_n = beep_cnt;
        snz_n      = snooze_cnt;
        tone_n     = tone_out;
        if (!arm) begin
            state_n    = S_IDLE;
            phase_n    = '0;
            tone_cnt_n = '0;
            beep_cnt_n = '0;
            snz_n      = '0;
            tone_n     = 1'b0;
        end else if (stop && (is_ringing || state == S_SNOOZE)) begin
            state_n    = S_DONE;
            phase_n    = '0;
            tone_cnt_n = '0;
            tone_n     = 1'b0;
        end else if (snooze && is_ringing && (snooze_cnt < SNZ_MAX)) begin
            state_n    = S_SNOOZE;
            snz_n      = snooze_cnt + 2'd1;
            phase_n    = '0;
            tone_cnt_n = '0;
            tone_n     = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (alarm_in) begin
                        state_n    = S_BEEP_ON;
                        phase_n    = '0;
                        tone_cnt_n = '0;
                        beep_cnt_n = '0;
                        snz_n      = '0;
                        tone_n     = 1'b1;
                    end
                end
                S_BEEP_ON: begin
                    if (phase == ON_LAST) begin
                        state_n    = S_BEEP_OFF;
                        phase_n    = '0;
                        tone_cnt_n = '0;
                        tone_n     = 1'b0;
                    end else begin
                        phase_n = phase + 1'b1;
                        if (tone_cnt == TONE_LAST) begin
                            tone_cnt_n = '0;
                            tone_n     = ~tone_out;
                        end else begin
                            tone_cnt_n = tone_cnt + 1'b1;
                        end
                    end
                end
                S_BEEP_OFF: begin
                    if (phase == OFF_LAST) begin
                        phase_n    = '0;
                        beep_cnt_n = beep_cnt + 1'b1;
                        if (beep_cnt == BEEP_LAST) begin
                            state_n = S_DONE;
                        end else begin
                            state_n    = S_BEEP_ON;
                            tone_cnt_n = '0;
                            tone_n     = 1'b1;
                        end
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                S_SNOOZE: begin
                    if (phase == SNZ_LAST) begin
                        state_n    = S_BEEP_ON;
                        phase_n    = '0;
                        tone_cnt_n = '0;
                        beep_cnt_n = '0;
                        tone_n     = 1'b1;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                S_DONE: begin
                    // Held until the request drops so the same match window cannot re-trigger.
                    if (!alarm_in) begin
                        state_n = S_IDLE;
                        phase_n = '0;
                    end
                end
                default: begin
                    state_n    = S_IDLE;
                    phase_n    = '0;
                    tone_cnt_n = '0;
                    beep_cnt_n = '0;
                    snz_n      = '0;
                    tone_n     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            phase      <= '0;
            tone_cnt   <= '0;
            beep_cnt   <= '0;
            snooze_cnt <= '0;
            tone_out   <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            tone_cnt   <= tone_cnt_n;
            beep_cnt   <= beep_cnt_n;
            snooze_cnt <= snz_n;
            tone_out   <= tone_n;
            ringing    <= (state_n == S_BEEP_ON) || (state_n == S_BEEP_OFF);
            snoozing   <= (state_n == S_SNOOZE);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_alarm_beeper.sv
// Bench for alarm_beeper: randomized and directed stimulus against an elapsed-time
// reference model, with a queue-based scoreboard checked every cycle.
module tb_alarm_beeper;

  localparam int TH     = 4;
  localparam int ON     = 16;
  localparam int OFF    = 16;
  localparam int SL     = 64;
  localparam int TOUT   = 8;
  localparam int MS     = 3;
  localparam int PERIOD = ON + OFF;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 3;
  localparam int M_DONE = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  logic alarm_in = 1'b0, arm = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic tone_out, ringing, snoozing;
  logic [1:0] snooze_cnt;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  alarm_beeper dut (
    .clk(clk), .reset_n(reset_n), .alarm_in(alarm_in), .arm(arm),
    .snooze(snooze), .stop(stop), .tone_out(tone_out), .ringing(ringing),
    .snoozing(snoozing), .snooze_cnt(snooze_cnt), .state_o(state_o)
  );

  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // reference model: one elapsed-time counter per ringing session
  int m_mode, m_ring_t, m_snz_t, m_snoozes;

  task automatic model_reset();
    m_mode = M_IDLE; m_ring_t = 0; m_snz_t = 0; m_snoozes = 0;
  endtask

  task automatic model_step(input logic a, input logic ar, input logic sz, input logic st);
    if (!ar) begin
      m_mode = M_IDLE; m_snoozes = 0;
    end else if (st && (m_mode == M_RING || m_mode == M_SNZ)) begin
      m_mode = M_DONE;
    end else if (sz && m_mode == M_RING && m_snoozes < MS) begin
      m_mode = M_SNZ; m_snz_t = 0; m_snoozes++;
    end else begin
      case (m_mode)
        M_IDLE: if (a) begin m_mode = M_RING; m_ring_t = 0; m_snoozes = 0; end
        M_RING: begin
          m_ring_t++;
          if (m_ring_t == TOUT * PERIOD) m_mode = M_DONE;
        end
        M_SNZ: begin
          m_snz_t++;
          if (m_snz_t == SL) begin m_mode = M_RING; m_ring_t = 0; end
        end
        default: if (!a) m_mode = M_IDLE;
      endcase
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [2:0] st;
    logic tone, ring, snzg;
    int pos;
    st = 3'd0; tone = 1'b0; ring = 1'b0; snzg = 1'b0;
    case (m_mode)
      M_RING: begin
        ring = 1'b1;
        pos = m_ring_t % PERIOD;
        if (pos < ON) begin
          st = 3'd1;
          tone = ((pos / TH) % 2) == 0;
        end else begin
          st = 3'd2;
        end
      end
      M_SNZ:  begin st = 3'd3; snzg = 1'b1; end
      M_DONE: st = 3'd4;
      default: st = 3'd0;
    endcase
    return {st, tone, ring, snzg, 2'(m_snoozes)};
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (state,tone,ring,snz,cnt) t=%0t", name, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic a, input logic ar, input logic sz, input logic st);
    @(negedge clk);
    alarm_in = a; arm = ar; snooze = sz; stop = st;
    model_step(a, ar, sz, st);
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    alarm_in = 1'b0; snooze = 1'b0; stop = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {state_o, tone_out, ringing, snoozing, snooze_cnt}, 8'h00);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // monitor: compares every presented output cycle against the queue
  logic [7:0] mon_exp;
  always @(posedge clk) begin
    #1;
    if (reset_n === 1'b1 && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      chk("cycle_out", {state_o, tone_out, ringing, snoozing, snooze_cnt}, mon_exp);
    end
  end

  initial begin
    model_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk("reset_state", {state_o, tone_out, ringing, snoozing, snooze_cnt}, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0);

    // full timeout sequence, then release of the request
    run(262);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0);

    // snooze in the fifth cycle of the first burst, then stop
    run(5);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    run(70);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0);

    // four snoozes: the last one exceeds the limit
    run(1);
    for (int k = 0; k < 4; k++) begin
      run(3);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      run(70);
    end
    run(10);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // stop and snooze together during the gap
    run(3);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    run(66 + ON);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    run(5);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0);

    // arm dropped while snoozing, then restart
    run(3);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    run(10);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    run(6);

    // asynchronous reset in the middle of a burst
    pulse_reset();
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0);
    run(4);

    // randomized traffic
    begin
      logic a_lvl;
      a_lvl = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 39) == 0) a_lvl = ~a_lvl;
        drive(a_lvl, $urandom_range(0, 199) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 79) == 0);
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_beeper.md
ALARM_BEEPER -- requirements
Module: alarm_beeper

Interface
REQ-001 Parameter TONE_HALF, default 4: clk cycles per half-period of the tone square wave.
REQ-002 Parameter BEEP_ON_LEN, default 16: clk cycles per audible burst.
REQ-003 Parameter BEEP_OFF_LEN, default 16: clk cycles of silence between bursts.
REQ-004 Parameter SNOOZE_LEN, default 64: clk cycles of silence after an accepted snooze.
REQ-005 Parameter TIMEOUT_BEEPS, default 8: completed burst+gap cycles before auto-stop.
REQ-006 Parameter MAX_SNOOZE, default 3: snoozes accepted per alarm event; range 1..3.
REQ-007 clk  input  1  system clock; all state updates on the rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 alarm_in  input  1  alarm request level from the upstream alarm state machine.
REQ-010 arm  input  1  alarm-enable toggle switch level; 0 cancels all activity.
REQ-011 snooze  input  1  snooze button, one-clk pulse, synchronous.
REQ-012 stop  input  1  stop button, one-clk pulse, synchronous.
REQ-013 tone_out  output  1  registered speaker drive.
REQ-014 ringing  output  1  registered; 1 in BEEP_ON or BEEP_OFF.
REQ-015 snoozing  output  1  registered; 1 in SNOOZE.
REQ-016 snooze_cnt  output  2  snoozes accepted in the current alarm event.
REQ-017 state_o  output  3  state encoding: IDLE=0, BEEP_ON=1, BEEP_OFF=2, SNOOZE=3, DONE=4.

Function
REQ-018 States IDLE, BEEP_ON, BEEP_OFF, SNOOZE, DONE; one shared phase counter, one tone counter, one beep counter.
REQ-019 Priority at every edge: arm==0 > stop > snooze > timer expiry > alarm_in.
REQ-020 arm==0 in any state -> IDLE next cycle; all counters cleared; snooze_cnt cleared.
REQ-021 IDLE: alarm_in==1 and arm==1 -> BEEP_ON next cycle; phase, tone and beep counters cleared; snooze_cnt cleared.
REQ-022 BEEP_ON: tone_out=1 for the first TONE_HALF cycles after entry, then toggles every TONE_HALF cycles; after BEEP_ON_LEN cycles -> BEEP_OFF.
REQ-023 BEEP_OFF: tone_out=0; after BEEP_OFF_LEN cycles the beep counter increments; if the count equals TIMEOUT_BEEPS -> DONE, else -> BEEP_ON.
REQ-024 Once in BEEP_ON/BEEP_OFF, ringing is latched; alarm_in falling does not stop it.
REQ-025 snooze in BEEP_ON or BEEP_OFF with snooze_cnt < MAX_SNOOZE -> SNOOZE; snooze_cnt increments; phase counter cleared.
REQ-026 snooze with snooze_cnt == MAX_SNOOZE is ignored; snooze in IDLE, SNOOZE or DONE is ignored.
REQ-027 SNOOZE: tone_out=0; alarm_in ignored; after SNOOZE_LEN cycles -> BEEP_ON with beep and tone counters cleared.
REQ-028 stop in BEEP_ON, BEEP_OFF or SNOOZE -> DONE next cycle; stop in IDLE or DONE is ignored.
REQ-029 DONE: tone_out=0; remains until alarm_in==0, then -> IDLE; prevents re-trigger on the same match window.
REQ-030 stop and snooze in the same cycle: stop wins (-> DONE); snooze_cnt unchanged.
REQ-031 All outputs are registered and reflect the new state in the same cycle as state_o.
REQ-032 All counters are sized from their parameters; no counter wraps before its terminal compare.

Reset
REQ-033 reset_n low: state IDLE; tone_out, ringing, snoozing = 0; snooze_cnt = 0; all counters = 0, effective immediately and independent of clk.
REQ-034 Reset asserted mid-burst or mid-snooze aborts the operation; after release the block waits in IDLE for alarm_in.

Verification
REQ-035 Defaults, arm=1, alarm_in rises and stays high -> ringing=1 next cycle; tone_out pattern 1111 0000 1111 0000, then 16 zeros; after 256 cycles state_o=4; returns to 0 the cycle after alarm_in drops.
REQ-036 Snooze pulse at cycle 5 of the first burst -> state_o=3, tone_out=0 for 64 cycles, then BEEP_ON with tone_out=1; snooze_cnt=1.
REQ-037 Four snooze pulses, one per ringing period -> first three accepted (snooze_cnt=3), fourth ignored; ringing stays 1.
REQ-038 stop and snooze in the same cycle during BEEP_OFF -> state_o=4, snooze_cnt unchanged; alarm_in still high keeps DONE.
REQ-039 arm dropped to 0 during SNOOZE -> state_o=0, snooze_cnt=0, tone_out=0 next cycle; arm=1 with alarm_in=1 restarts ringing.
REQ-040 reset_n pulsed low mid-burst between clock edges -> tone_out and ringing 0 immediately; state_o=0 after release.
